// File: rtl/change_dispenser.sv
// Vend/change actuator sequencer: vend pulse, then greedy 2-unit/1-unit coin pulses separated by gaps.
// Optional VEND_COUNT_EN adds saturating vend_count / coins_out statistics outputs.
module change_dispenser #(
  parameter int unsigned PRICE        = 5,
  parameter int unsigned MAX_CODE     = 8,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  state_in,
  input  logic        state_valid,
  output logic        busy,
  output logic        vend_pulse,
  output logic        coin2_pulse,
  output logic        coin1_pulse,
  output logic        done,
  output logic        overrun,
  output logic        err
`ifdef VEND_COUNT_EN
  ,
  output logic [15:0] vend_count,
  output logic [15:0] coins_out
`endif
);

  localparam int unsigned MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int unsigned CHW  = ((MAX_CODE - PRICE) > 1) ? $clog2(MAX_CODE - PRICE + 1) : 1;
  localparam logic [CW-1:0]  PULSE_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]  GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]     PRICE_C  = 4'(PRICE);
  localparam logic [3:0]     MAX_C    = 4'(MAX_CODE);

  typedef enum logic [2:0] {
    S_IDLE, S_VEND, S_GAP, S_COIN2, S_COIN1, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CHW-1:0]   change_q, change_d;
  logic             busy_q, busy_d, vend_q, vend_d, coin2_q, coin2_d;
  logic             coin1_q, coin1_d, done_q, done_d, overrun_q, err_q;
  logic             code_err, code_vend;

  assign code_err  = state_valid && (state_in > MAX_C);
  assign code_vend = state_valid && (state_in >= PRICE_C) && !(state_in > MAX_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      change_q  <= '0;
      busy_q    <= 1'b0;
      vend_q    <= 1'b0;
      coin2_q   <= 1'b0;
      coin1_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      change_q <= change_d;
      busy_q   <= busy_d;
      vend_q   <= vend_d;
      coin2_q  <= coin2_d;
      coin1_q  <= coin1_d;
      done_q   <= done_d;
      if (code_vend && (state_q != S_IDLE)) overrun_q <= 1'b1;
      if (code_err) err_q <= 1'b1;
    end
  end

  // Counter reloads with N-1 on every state entry; the state exits when it reaches zero.
  always_comb begin
    state_d  = state_q;
    change_d = change_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    unique case (state_q)
      S_IDLE: if (code_vend) begin
        state_d  = S_VEND;
        cnt_d    = PULSE_LD;
        change_d = CHW'(state_in - PRICE_C);
      end
      S_VEND: if (cnt_q == '0) begin
        state_d = S_GAP;
        cnt_d   = GAP_LD;
      end
      S_GAP: if (cnt_q == '0) begin
        cnt_d = PULSE_LD;
        if (change_q >= CHW'(2))      state_d = S_COIN2;
        else if (change_q == CHW'(1)) state_d = S_COIN1;
        else                          state_d = S_DONE;
      end
      S_COIN2: if (cnt_q == '0) begin
        state_d  = S_GAP;
        cnt_d    = GAP_LD;
        change_d = change_q - CHW'(2);
      end
      S_COIN1: if (cnt_q == '0) begin
        state_d  = S_GAP;
        cnt_d    = GAP_LD;
        change_d = change_q - CHW'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered pulses line up with the state register.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    vend_d  = (state_d == S_VEND);
    coin2_d = (state_d == S_COIN2);
    coin1_d = (state_d == S_COIN1);
    done_d  = (state_d == S_DONE);
  end

  assign busy        = busy_q;
  assign vend_pulse  = vend_q;
  assign coin2_pulse = coin2_q;
  assign coin1_pulse = coin1_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign err         = err_q;

`ifdef VEND_COUNT_EN
  logic [15:0] vend_count_q, coins_out_q;
  logic        vend_entry, coin_entry;

  assign vend_entry = (state_d == S_VEND) && (state_q != S_VEND);
  assign coin_entry = ((state_d == S_COIN2) || (state_d == S_COIN1)) && (state_q == S_GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vend_count_q <= '0;
      coins_out_q  <= '0;
    end else begin
      if (vend_entry && (vend_count_q != '1)) vend_count_q <= vend_count_q + 16'd1;
      if (coin_entry && (coins_out_q != '1))  coins_out_q  <= coins_out_q + 16'd1;
    end
  end

  assign vend_count = vend_count_q;
  assign coins_out  = coins_out_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser (PULSE=GAP=4, PRICE=5, MAX_CODE=8).
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state_in = '0;
  logic       state_valid = 1'b0;
  logic       busy, vend_pulse, coin2_pulse, coin1_pulse, done, overrun, err;
`ifdef VEND_COUNT_EN
  logic [15:0] vend_count, coins_out;
`endif

  int total = 0;
  int bad   = 0;

  int n_vc, n_vp, n_c2, n_c1, n_busy, n_done, n_excl, t_done, t_c2, t_c1;

  change_dispenser #(
    .PRICE(5), .MAX_CODE(8), .PULSE_CYCLES(4), .GAP_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .state_valid(state_valid),
    .busy(busy), .vend_pulse(vend_pulse), .coin2_pulse(coin2_pulse),
    .coin1_pulse(coin1_pulse), .done(done), .overrun(overrun), .err(err)
`ifdef VEND_COUNT_EN
    , .vend_count(vend_count), .coins_out(coins_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    state_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the first negedge after the capturing posedge (window cycle 0).
  task automatic strobe(input logic [3:0] code);
    @(negedge clk);
    state_in = code;
    state_valid = 1'b1;
    @(negedge clk);
    state_valid = 1'b0;
  endtask

  task automatic window(input int ncyc);
    logic pv, p2, p1;
    pv = 1'b0; p2 = 1'b0; p1 = 1'b0;
    n_vc = 0; n_vp = 0; n_c2 = 0; n_c1 = 0; n_busy = 0; n_done = 0; n_excl = 0;
    t_done = -1; t_c2 = -1; t_c1 = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (vend_pulse) n_vc++;
      if (vend_pulse && !pv) n_vp++;
      if (coin2_pulse && !p2) begin n_c2++; if (t_c2 < 0) t_c2 = k; end
      if (coin1_pulse && !p1) begin n_c1++; if (t_c1 < 0) t_c1 = k; end
      if (busy) n_busy++;
      if (done) begin n_done++; if (t_done < 0) t_done = k; if (!busy) n_excl++; end
      if ((32'(vend_pulse) + 32'(coin2_pulse) + 32'(coin1_pulse)) > 1) n_excl++;
      pv = vend_pulse; p2 = coin2_pulse; p1 = coin1_pulse;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy, vend_pulse, coin2_pulse, coin1_pulse, done, overrun, err} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0000000",
        {busy, vend_pulse, coin2_pulse, coin1_pulse, done, overrun, err});
    end
    apply_reset();
    // Async reset in the middle of a coin2 pulse for code 8 (coin2 spans window cycles 8..11).
    strobe(4'd8);
    repeat (9) @(negedge clk);
    total++;
    if (coin2_pulse !== 1'b1) begin bad++; $display("FAIL reset_pre_coin2: got %b want 1", coin2_pulse); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, vend_pulse, coin2_pulse, coin1_pulse, done, overrun, err} !== 7'b0) begin
      bad++; $display("FAIL reset_async: got %b want 0000000",
        {busy, vend_pulse, coin2_pulse, coin1_pulse, done, overrun, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    window(30);
    total++;
    if (n_busy !== 0 || n_vp !== 0 || n_c2 !== 0 || n_c1 !== 0) begin
      bad++; $display("FAIL reset_no_resume: busy=%0d vend=%0d c2=%0d c1=%0d want all 0",
        n_busy, n_vp, n_c2, n_c1);
    end
  endtask

  task automatic test_vend(input string nm, input logic [3:0] code,
                           input int exp_c2, input int exp_c1, input int exp_done_at);
    int exp_vc, exp_vp, exp_busy, exp_nd, exp_t2, exp_t1;
    apply_reset();
    exp_vp   = (exp_done_at >= 0) ? 1 : 0;
    exp_vc   = 4 * exp_vp;
    exp_busy = exp_done_at + 1;
    exp_nd   = exp_vp;
    exp_t2   = (exp_c2 > 0) ? 8 : -1;
    exp_t1   = (exp_c1 > 0) ? ((exp_c2 > 0) ? 16 : 8) : -1;
    strobe(code);
    total++;
    if (vend_pulse !== exp_vp[0]) begin
      bad++; $display("FAIL %s_latency: vend_pulse=%b want %b", nm, vend_pulse, exp_vp[0]);
    end
    window(40);
    total++;
    if (n_vc !== exp_vc || n_vp !== exp_vp) begin
      bad++; $display("FAIL %s_vend: cycles=%0d pulses=%0d want %0d/%0d", nm, n_vc, n_vp, exp_vc, exp_vp);
    end
    total++;
    if (n_c2 !== exp_c2 || n_c1 !== exp_c1) begin
      bad++; $display("FAIL %s_coins: c2=%0d c1=%0d want %0d/%0d", nm, n_c2, n_c1, exp_c2, exp_c1);
    end
    total++;
    if (t_c2 !== exp_t2 || t_c1 !== exp_t1) begin
      bad++; $display("FAIL %s_coin_timing: t_c2=%0d t_c1=%0d want %0d/%0d", nm, t_c2, t_c1, exp_t2, exp_t1);
    end
    total++;
    if (n_busy !== exp_busy || t_done !== exp_done_at || n_done !== exp_nd) begin
      bad++; $display("FAIL %s_busy_done: busy=%0d t_done=%0d ndone=%0d want %0d/%0d/%0d",
        nm, n_busy, t_done, n_done, exp_busy, exp_done_at, exp_nd);
    end
    total++;
    if (n_excl !== 0 || overrun !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL %s_exclusive: excl=%0d overrun=%b err=%b want 0/0/0", nm, n_excl, overrun, err);
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    strobe(4'd5);
    repeat (2) @(negedge clk);
    state_in = 4'd6;
    state_valid = 1'b1;
    @(negedge clk);
    state_valid = 1'b0;
    window(30);
    total++;
    if (overrun !== 1'b1 || n_vp !== 1 || n_c1 !== 0 || n_done !== 1) begin
      bad++; $display("FAIL overrun_busy: overrun=%b vend=%0d c1=%0d done=%0d want 1/1/0/1",
        overrun, n_vp, n_c1, n_done);
    end
  endtask

  task automatic test_done_overrun();
    bit seen;
    apply_reset();
    strobe(4'd5);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL done_wait: done=0 want 1 within 40 cycles"); end
    state_in = 4'd6;
    state_valid = 1'b1;
    @(negedge clk);
    state_valid = 1'b0;
    window(30);
    total++;
    if (overrun !== 1'b1 || n_vp !== 0) begin
      bad++; $display("FAIL done_overrun: overrun=%b vend=%0d want 1/0", overrun, n_vp);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    apply_reset();
    strobe(4'd5);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    @(negedge clk);
    total++;
    if (!seen || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: seen_done=%b busy=%b want 1/0", seen, busy);
    end
    state_in = 4'd7;
    state_valid = 1'b1;
    @(negedge clk);
    state_valid = 1'b0;
    window(30);
    total++;
    if (n_vp !== 1 || n_c2 !== 1 || n_c1 !== 0 || overrun !== 1'b0 || t_done !== 16) begin
      bad++; $display("FAIL b2b_second: vend=%0d c2=%0d c1=%0d overrun=%b t_done=%0d want 1/1/0/0/16",
        n_vp, n_c2, n_c1, overrun, t_done);
    end
  endtask

  task automatic test_err();
    apply_reset();
    strobe(4'hA);
    window(30);
    total++;
    if (err !== 1'b1 || n_vp !== 0 || n_busy !== 0 || overrun !== 1'b0) begin
      bad++; $display("FAIL err_code_a: err=%b vend=%0d busy=%0d overrun=%b want 1/0/0/0",
        err, n_vp, n_busy, overrun);
    end
    strobe(4'd5);
    window(20);
    total++;
    if (err !== 1'b1 || n_vp !== 1) begin
      bad++; $display("FAIL err_sticky: err=%b vend=%0d want 1/1", err, n_vp);
    end
    apply_reset();
    strobe(4'd9);
    window(20);
    total++;
    if (err !== 1'b1 || n_vp !== 0) begin
      bad++; $display("FAIL err_code_9: err=%b vend=%0d want 1/0", err, n_vp);
    end
  endtask

`ifdef VEND_COUNT_EN
  task automatic test_counts();
    apply_reset();
    total++;
    if (vend_count !== 16'd0 || coins_out !== 16'd0) begin
      bad++; $display("FAIL count_reset: vend_count=%0d coins_out=%0d want 0/0", vend_count, coins_out);
    end
    strobe(4'd5); window(40);
    strobe(4'd7); window(40);
    strobe(4'd8); window(40);
    total++;
    if (vend_count !== 16'd3 || coins_out !== 16'd3) begin
      bad++; $display("FAIL count_three: vend_count=%0d coins_out=%0d want 3/3", vend_count, coins_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_vend("code5", 4'd5, 0, 0, 8);
    test_vend("code6", 4'd6, 0, 1, 16);
    test_vend("code7", 4'd7, 1, 0, 16);
    test_vend("code8", 4'd8, 1, 1, 24);
    test_vend("code4", 4'd4, 0, 0, -1);
    test_vend("code3", 4'd3, 0, 0, -1);
    test_overrun();
    test_done_overrun();
    test_back_to_back();
    test_err();
`ifdef VEND_COUNT_EN
    test_counts();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
